// File: rtl/hsuart_pkg.sv
// Shared UART types and defaults for the TX core and the future RX core.
package hsuart_pkg;

  localparam int HSUART_DATA_BITS  = 8;
  localparam int HSUART_FIFO_DEPTH = 16;
  localparam int HSUART_DIV_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Frame options captured when a byte leaves the FIFO; the parity bit is
  // precomputed at that point so the serialiser only has to shift it out.
  typedef struct packed {
    logic par_en;
    logic par_bit;
    logic stop2;
  } tx_frame_cfg_t;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic frame_parity(input logic [HSUART_DATA_BITS-1:0] d,
                                        input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/hsuart_tx_core_if.sv
// Byte push channel from the register block into the TX core.
interface hsuart_tx_core_if;
  import hsuart_pkg::*;

  logic                        wr_valid;
  logic [HSUART_DATA_BITS-1:0] wr_data;
  logic                        wr_ready;
  logic                        wr_ovf;

  modport master (output wr_valid, output wr_data, input wr_ready, input wr_ovf);
  modport slave  (input wr_valid, input wr_data, output wr_ready, output wr_ovf);

endinterface

// File: rtl/hsuart_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers and registered level/flags.
// Shared between the TX and RX paths.
module hsuart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr, wptr_nxt, rptr_nxt, level_nxt;
  logic             do_push, do_pop;

  // Requests against a full/empty FIFO are ignored here, so callers need
  // no extra guarding.
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign wptr_nxt  = wptr + LW'(do_push);
  assign rptr_nxt  = rptr + LW'(do_pop);
  assign level_nxt = wptr_nxt - rptr_nxt;
  assign rd_data   = mem[rptr[AW-1:0]];

  // Storage array; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wr_data;
  end

  // Pointers and flags; flags come from next-state values so they are flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      wptr  <= wptr_nxt;
      rptr  <= rptr_nxt;
      level <= level_nxt;
      empty <= (level_nxt == '0);
      full  <= (level_nxt == LW'(DEPTH));
    end
  end

endmodule

// File: rtl/hsuart_tx_core.sv
// UART transmit engine: byte FIFO plus START/DATA/PARITY/STOP serialiser.
// Every output is a flop; tx idles high.
module hsuart_tx_core
  import hsuart_pkg::*;
#(
  parameter int FIFO_DEPTH = HSUART_FIFO_DEPTH,
  parameter int DIV_W      = HSUART_DIV_W
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [DIV_W-1:0]             baud_div,
  input  logic                         parity_en,
  input  logic                         parity_odd,
  input  logic                         stop2,
  hsuart_tx_core_if.slave              wr,
  output logic                         tx,
  output logic                         busy,
  output logic                         tx_done,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         fifo_empty,
  output logic                         fifo_full
);

  localparam int BW = $clog2(HSUART_DATA_BITS);

  tx_state_t                   state, state_nxt;
  tx_frame_cfg_t               cfg_l;
  logic [DIV_W-1:0]            cnt, div_l, div_in;
  logic [BW-1:0]               bit_idx;
  logic [HSUART_DATA_BITS-1:0] shreg, fifo_rd;
  logic                        stop_second, bit_end, last_stop;
  logic                        pop, load_cnt, tx_nxt, done_nxt, ovf_q;

  hsuart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (HSUART_DATA_BITS)
  ) u_fifo (
    .clk     (ACLK),
    .rst     (ARESET),
    .push    (wr.wr_valid),
    .wr_data (wr.wr_data),
    .pop     (pop),
    .rd_data (fifo_rd),
    .level   (fifo_level),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign wr.wr_ready = !fifo_full;
  assign wr.wr_ovf   = ovf_q;

  // A zero divisor would give a 1-clock bit; clamp so the shortest bit is 2.
  assign div_in    = (baud_div == '0) ? DIV_W'(1) : baud_div;
  assign bit_end   = (cnt == '0);
  assign last_stop = !cfg_l.stop2 || stop_second;

  // FSM state register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state; STOP chains straight into START when more bytes wait.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!fifo_empty) state_nxt = START;
      START:  if (bit_end) state_nxt = DATA;
      DATA:   if (bit_end && bit_idx == BW'(HSUART_DATA_BITS - 1))
                state_nxt = cfg_l.par_en ? PARITY : STOP;
      PARITY: if (bit_end) state_nxt = STOP;
      STOP:   if (bit_end && last_stop)
                state_nxt = fifo_empty ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: pop strobe, timer reload, next line level, done pulse.
  always_comb begin
    pop      = (state_nxt == START) && (state == IDLE || state == STOP);
    load_cnt = pop || (state != IDLE && bit_end);
    tx_nxt   = tx;
    if (state == IDLE) begin
      tx_nxt = !pop;
    end else if (bit_end) begin
      case (state_nxt)
        START:   tx_nxt = 1'b0;
        // Entering DATA shows bit 0; later data bits show the bit the
        // shift register is about to move into position 0.
        DATA:    tx_nxt = (state == START) ? shreg[0] : shreg[1];
        PARITY:  tx_nxt = cfg_l.par_bit;
        default: tx_nxt = 1'b1;
      endcase
    end
    // Timer reloads with at least 1, so cnt==1 always precedes the last
    // clock of a bit; flagging it here makes tx_done land on that clock.
    done_nxt = (state == STOP) && last_stop && (cnt == DIV_W'(1));
  end

  // Registered status outputs.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      tx      <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      tx      <= tx_nxt;
      busy    <= (state_nxt != IDLE);
      tx_done <= done_nxt;
      ovf_q   <= wr.wr_valid && fifo_full;
    end
  end

  // Frame datapath: capture byte and config at pop, shift during DATA.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      shreg       <= '0;
      cfg_l       <= '0;
      div_l       <= '0;
      bit_idx     <= '0;
      stop_second <= 1'b0;
    end else if (pop) begin
      shreg         <= fifo_rd;
      div_l         <= div_in;
      cfg_l.par_en  <= parity_en;
      cfg_l.par_bit <= frame_parity(fifo_rd, parity_odd);
      cfg_l.stop2   <= stop2;
      bit_idx       <= '0;
      stop_second   <= 1'b0;
    end else begin
      if (state == DATA && bit_end) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + BW'(1);
      end
      if (state == STOP && bit_end) stop_second <= 1'b1;
    end
  end

  // Bit timer: counts div..0, so each bit lasts div+1 clocks.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cnt <= '0;
    end else if (load_cnt) begin
      cnt <= pop ? div_in : div_l;
    end else if (state != IDLE) begin
      cnt <= cnt - DIV_W'(1);
    end
  end

endmodule

// File: tb/tb_hsuart_tx_core.sv
// Scoreboard bench for hsuart_tx_core: stimulus queues expected frames,
// a line monitor checks each frame clock by clock as it appears on tx.
module tb_hsuart_tx_core;
  import hsuart_pkg::*;

  localparam int DEPTH = 16;
  localparam int DW    = 16;

  logic          ACLK, ARESET;
  logic [DW-1:0] baud_div;
  logic          parity_en, parity_odd, stop2;
  logic          tx, busy, tx_done, fifo_empty, fifo_full;
  logic [4:0]    fifo_level;

  hsuart_tx_core_if wr_if ();

  hsuart_tx_core #(.FIFO_DEPTH(DEPTH), .DIV_W(DW)) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .wr         (wr_if),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .fifo_level (fifo_level),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full)
  );

  typedef struct {
    logic [7:0] data;
    bit         par_en;
    bit         par_bit;
    bit         stop2;
    int         per;     // clocks per bit
    int         len;     // clocks per frame
    bit         contig;  // must start right after the previous frame
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_busy = 0;

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input bit pe, input bit pb,
                              input bit s2, input int per, input int len, input bit contig);
    exp_t e;
    e.data = d; e.par_en = pe; e.par_bit = pb; e.stop2 = s2;
    e.per = per; e.len = len; e.contig = contig;
    return e;
  endfunction

  // Called at posedge+1; offers one byte for one clock.
  task automatic write_byte(input exp_t e, input bit accept);
    check("wr_ready", 32'(wr_if.wr_ready), 32'(accept));
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = e.data;
    @(posedge ACLK); #1;
    wr_if.wr_valid = 1'b0;
    check("wr_ovf", 32'(wr_if.wr_ovf), 32'(!accept));
    if (accept) exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int max_clk);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < max_clk) begin
      @(posedge ACLK); n++;
    end
    #1;
    check("drain_timeout", 32'(exp_q.size() != 0 || mon_busy), 0);
    repeat (3) @(posedge ACLK);
    #1;
  endtask

  // Line monitor: every low tx outside reset must be the start of a queued frame.
  initial begin : monitor
    int         gap, k, bad_tx, bad_done, bad_busy;
    bit         aborted;
    exp_t       e;
    logic [15:0] seq;
    gap = 1000;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        gap = 1000;
      end else if (tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_start", 32'(tx), 1);
          for (int w = 0; w < 20000 && busy === 1'b1; w++) @(negedge ACLK);
        end else begin
          e = exp_q.pop_front();
          mon_busy = 1;
          if (e.contig) check($sformatf("gap[%02h]", e.data), 32'(gap), 0);
          seq = '1;
          k = 0;
          seq[k] = 1'b0; k++;
          for (int b = 0; b < 8; b++) begin seq[k] = e.data[b]; k++; end
          if (e.par_en) begin seq[k] = e.par_bit; k++; end
          bad_tx = 0; bad_done = 0; bad_busy = 0; aborted = 0;
          for (int i = 0; i < e.len; i++) begin
            if (i > 0) @(negedge ACLK);
            if (ARESET) begin aborted = 1; break; end
            if (tx !== seq[i / e.per]) bad_tx++;
            if (tx_done !== (i == e.len - 1)) bad_done++;
            if (busy !== 1'b1) bad_busy++;
          end
          if (!aborted) begin
            check($sformatf("frame_tx[%02h]", e.data), 32'(bad_tx), 0);
            check($sformatf("frame_done[%02h]", e.data), 32'(bad_done), 0);
            check($sformatf("frame_busy[%02h]", e.data), 32'(bad_busy), 0);
            gap = 0;
            if (exp_q.size() == 0) begin
              @(negedge ACLK);
              check("busy_fall_busy_tx", 32'({busy, tx}), 32'b01);
              gap = 1;
            end
          end else begin
            gap = 1000;
          end
          mon_busy = 0;
        end
      end else begin
        gap++;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int bad;
    ARESET = 1'b0;
    baud_div = 16'd3; parity_en = 0; parity_odd = 0; stop2 = 0;
    wr_if.wr_valid = 1'b0; wr_if.wr_data = 8'h00;
    #1 ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_tx", 32'(tx), 1);
    check("rst_wr_ready", 32'(wr_if.wr_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_tx_done", 32'(tx_done), 0);
    check("rst_wr_ovf", 32'(wr_if.wr_ovf), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_empty", 32'(fifo_empty), 1);
    check("rst_full", 32'(fifo_full), 0);
    ARESET = 1'b0;
    @(posedge ACLK); #1;

    // Basic frame 0x55 at 4 clocks/bit, plus push-to-start latency.
    write_byte(mk(8'h55, 0, 0, 0, 4, 40, 0), 1);
    check("push_empty", 32'(fifo_empty), 0);
    check("push_level", 32'(fifo_level), 1);
    check("push_tx_idle", 32'(tx), 1);
    @(posedge ACLK); #1;
    check("pop_tx_start", 32'(tx), 0);
    check("pop_busy", 32'(busy), 1);
    check("pop_empty", 32'(fifo_empty), 1);
    wait_drain(200);

    // Parity on 0x07 (three ones): even -> 1, odd -> 0.
    parity_en = 1; parity_odd = 0;
    write_byte(mk(8'h07, 1, 1, 0, 4, 44, 0), 1);
    wait_drain(200);
    parity_odd = 1;
    write_byte(mk(8'h07, 1, 0, 0, 4, 44, 0), 1);
    wait_drain(200);
    parity_en = 0; parity_odd = 0;

    // Fill: one byte sits in the shifter, 16 in the FIFO, so 17 writes are
    // accepted and the 18th overflows.
    baud_div = 16'd100;
    for (int i = 0; i < 18; i++) begin
      if (i == 17) begin
        check("full_level", 32'(fifo_level), 16);
        check("full_flag", 32'(fifo_full), 1);
      end
      write_byte(mk(8'(i + 8'h40), 0, 0, 0, 101, 1010, i > 0), i < 17);
    end
    @(posedge ACLK); #1;
    check("wr_ovf_pulse_end", 32'(wr_if.wr_ovf), 0);
    wait_drain(20000);

    // Back-to-back, two stop bits.
    baud_div = 16'd3; stop2 = 1;
    write_byte(mk(8'hA5, 0, 0, 1, 4, 44, 0), 1);
    write_byte(mk(8'h3C, 0, 0, 1, 4, 44, 1), 1);
    wait_drain(300);
    stop2 = 0;

    // Divisor 0 gives 2-clock bits; a mid-frame change only hits the next frame.
    baud_div = 16'd0;
    write_byte(mk(8'hC3, 0, 0, 0, 2, 20, 0), 1);
    repeat (5) @(posedge ACLK);
    #1;
    baud_div = 16'd7;
    write_byte(mk(8'h81, 0, 0, 0, 8, 80, 1), 1);
    wait_drain(300);

    // Reset during DATA of the first of four queued bytes.
    baud_div = 16'd3;
    write_byte(mk(8'h11, 0, 0, 0, 4, 40, 0), 1);
    write_byte(mk(8'h22, 0, 0, 0, 4, 40, 1), 1);
    write_byte(mk(8'h33, 0, 0, 0, 4, 40, 1), 1);
    write_byte(mk(8'h44, 0, 0, 0, 4, 40, 1), 1);
    repeat (8) @(posedge ACLK);
    #2;
    ARESET = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_tx", 32'(tx), 1);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_level", 32'(fifo_level), 0);
    check("mid_rst_empty", 32'(fifo_empty), 1);
    check("mid_rst_tx_done", 32'(tx_done), 0);
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge ACLK);
      if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    check("post_rst_quiet", 32'(bad), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
